fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Produces the one-hot operand-forwarding selects (fwdA/fwdB) consumed by the EX stage of the 5-stage MIPS pipeline.
- Detects load-use hazards and stalls IF/ID for one cycle, inserting a bubble into ID/EX.
- Tracks destination, write and load state for the EX, MEM and WB stages in internal shadow registers that advance in lockstep with the datapath pipeline registers.
- Keeps a saturating stall counter for performance analysis.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt; asserted for R-type, store and branch.
- id_dest  in  REG_AW  resolved destination register (Rd or Rt after the RegDst mux).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch taken; the ID instruction must be killed.
- fwdA  out  3  op1 select for the instruction in EX: 001 = ID/EX value, 010 = EX/MEM, 100 = MEM/WB.
- fwdB  out  3  op2 select for the instruction in EX; same encoding as fwdA.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- id_ex_bubble  out  1  load a bubble into ID/EX at the next edge (combinational).
- stall_count  out  CNT_W  number of load-use stall cycles since reset; saturates.

Behaviour:
- Shadow stages: EX, MEM and WB. Each holds {valid, dest, reg_write, mem_read}.
- Advance on every edge with rst_n=1:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (all fields 0) if id_ex_bubble, otherwise the ID fields.
- Write qualification: a stage "writes r" iff valid & reg_write & dest == r & dest != 0. Register 0 is never forwarded.
- Load-use hazard, combinational: EX.valid & EX.mem_read & EX.reg_write & EX.dest != 0 & id_valid & ((id_use_rs & id_rs == EX.dest) | (id_use_rt & id_rt == EX.dest)).
- stall = hazard & ~flush.
- id_ex_bubble = hazard | flush | ~id_valid. flush has priority: the killed instruction creates no stall and is not counted.
- fwdA/fwdB are registered with 1-cycle latency. They are computed from the ID instruction and loaded at the same edge the instruction enters EX, so they are valid for the whole EX cycle.
- Priority for the next fwdA (rs):
  - 010 if current EX writes rs (that instruction will then sit in EX/MEM).
  - else 100 if current MEM writes rs (will sit in MEM/WB).
  - else 001.
  - The youngest producer wins.
- fwdB uses the same rule with rt.
- If id_use_rs=0 (resp. id_use_rt=0), the select is 001.
- When a bubble enters EX, fwdA = fwdB = 001.
- After a load-use stall, the load sits in MEM when the consumer re-evaluates, so the consumer gets select 100. The one-cycle stall plus MEM/WB forwarding is sufficient.
- The WB-to-ID same-cycle write is covered by register-file write-before-read and is not forwarded here.
- stall_count increments by 1 on each edge where stall=1 and holds at all-ones.
- Reset values (an edge with rst_n=0):
  - All shadow stages invalid with fields 0.
  - fwdA = fwdB = 001; stall_count = 0.
  - stall and id_ex_bubble follow from the reset state: stall=0, id_ex_bubble=~id_valid.
- Reset mid-stall discards all pending hazards; the next cycle must not stall.
- Selects never take a value other than 001, 010 or 100.

Decomposition:
- Shared package pipe_pkg:
  - FWD_IDEX = 3'b001, FWD_EXMEM = 3'b010, FWD_MEMWB = 3'b100.
  - typedef stage_info_t {valid, dest, reg_write, mem_read}.
  - These are also used by the EX stage for its mux decode.
- Sub-module fwd_select: a combinational priority function taking (src, use, EX info, MEM info) and returning the 3-bit select. It is instantiated twice, once for A and once for B.

Test Plan:
- add $3,$1,$2 followed by sub $5,$3,$4 -> at sub's EX cycle fwdA=010, fwdB=001, stall never asserted.
- add $3,... ; nop ; or $6,$7,$3 -> or in EX: fwdA=001, fwdB=100.
- lw $4,0($1) followed by and $8,$4,$4 -> one cycle with stall=1 and id_ex_bubble=1; the next cycle and enters EX with fwdA=fwdB=100; stall_count=1.
- add $2,.. ; add $2,.. ; sub $9,$2,$2 -> fwdA=fwdB=010 (youngest producer wins).
- Writes to $0, or a producer with reg_write=0, followed by a consumer of $0 -> selects 001, no stall.
- lw $4 with a dependent instruction in ID and flush=1 -> stall=0, id_ex_bubble=1, stall_count unchanged.
- rst_n low for one edge during a stall -> fwdA=fwdB=001, stall_count=0, stall=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings and per-stage shadow info.
// The EX stage decodes the same select constants for its operand muxes.
package pipe_pkg;

    localparam int PIPE_AW = 5;

    localparam logic [2:0] FWD_IDEX  = 3'b001;
    localparam logic [2:0] FWD_EXMEM = 3'b010;
    localparam logic [2:0] FWD_MEMWB = 3'b100;

    typedef struct packed {
        logic               valid;
        logic [PIPE_AW-1:0] dest;
        logic               reg_write;
        logic               mem_read;
    } stage_info_t;

    // $0 is hardwired, so a stage never counts as producing it.
    function automatic logic stage_writes(input stage_info_t s, input logic [PIPE_AW-1:0] r);
        return s.valid && s.reg_write && (s.dest == r) && (s.dest != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding select for one source operand: the youngest in-flight producer wins.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  stage_info_t       ex_info,
    input  stage_info_t       mem_info,
    output logic [2:0]        sel
);

    always_comb begin
        sel = FWD_IDEX;
        if (use_src) begin
            if (stage_writes(ex_info, src)) begin
                sel = FWD_EXMEM;
            end else if (stage_writes(mem_info, src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects, load-use stall detection and a saturating stall counter.
// Shadow EX/MEM/WB stage info advances in lockstep with the datapath pipeline registers.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [2:0]        fwdA,
    output logic [2:0]        fwdB,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    import pipe_pkg::*;

    stage_info_t ex_q, ex_d;
    stage_info_t mem_q, mem_d;
    stage_info_t wb_q, wb_d;
    stage_info_t id_info;

    logic [2:0]       fwd_a_q, fwd_a_d, sel_a;
    logic [2:0]       fwd_b_q, fwd_b_d, sel_b;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard;

    fwd_select #(.REG_AW(REG_AW)) u_sel_a (
        .src      (id_rs),
        .use_src  (id_use_rs),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .sel      (sel_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_sel_b (
        .src      (id_rt),
        .use_src  (id_use_rt),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .sel      (sel_b)
    );

    always_comb begin
        id_info.valid     = id_valid;
        id_info.dest      = id_dest;
        id_info.reg_write = id_reg_write;
        id_info.mem_read  = id_mem_read;

        // A load in EX cannot forward its data until it reaches MEM/WB.
        hazard = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.dest != '0) && id_valid &&
                 ((id_use_rs && (id_rs == ex_q.dest)) || (id_use_rt && (id_rt == ex_q.dest)));

        stall        = hazard && !flush;
        id_ex_bubble = hazard || flush || !id_valid;

        ex_d  = id_ex_bubble ? '0 : id_info;
        mem_d = ex_q;
        wb_d  = mem_q;

        fwd_a_d = id_ex_bubble ? FWD_IDEX : sel_a;
        fwd_b_d = id_ex_bubble ? FWD_IDEX : sel_b;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            fwd_a_q       <= FWD_IDEX;
            fwd_b_q       <= FWD_IDEX;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwdA        = fwd_a_q;
    assign fwdB        = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed MIPS sequences then randomized traffic against an instruction-history model.
module tb_fwd_hazard_unit;

    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_dest;
    logic          id_use_rs, id_use_rt, id_reg_write, id_mem_read;
    logic          flush;
    logic [2:0]    fwdA, fwdB;
    logic          stall, id_ex_bubble;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Model: history of instructions that entered EX (index 0 = now in EX, 1 = now in MEM).
    typedef struct {
        bit v;
        int dest;
        bit rw;
        bit mr;
    } instr_t;

    instr_t hist[2];
    int     m_cnt;
    int     m_fa, m_fb;
    bit     obs_stall, obs_bub;

    function automatic bit produces(input instr_t e, input int r);
        return e.v && e.rw && (r != 0) && (e.dest == r);
    endfunction

    function automatic int pick(input bit use_it, input int r);
        if (!use_it) return 1;
        if (produces(hist[0], r)) return 2;
        if (produces(hist[1], r)) return 4;
        return 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist[0] = '{0, 0, 0, 0};
        hist[1] = '{0, 0, 0, 0};
        m_cnt = 0;
        m_fa = 1;
        m_fb = 1;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int dest, input bit rw, input bit mr);
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt);
        id_use_rs = urs; id_use_rt = urt; id_dest = AW'(dest);
        id_reg_write = rw; id_mem_read = mr;
    endtask

    // One clock: check combinational outputs, then registered outputs after the edge.
    task automatic step();
        bit hz, e_stall, e_bub;
        int na, nb;
        #1;
        obs_stall = stall;
        obs_bub = id_ex_bubble;
        hz = id_valid && hist[0].mr &&
             ((id_use_rs && produces(hist[0], int'(id_rs))) || (id_use_rt && produces(hist[0], int'(id_rt))));
        e_stall = hz && !flush;
        e_bub = hz || flush || !id_valid;
        if (rst_n) begin
            chk("stall", int'(stall), int'(e_stall));
            chk("id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
        end
        na = e_bub ? 1 : pick(id_use_rs, int'(id_rs));
        nb = e_bub ? 1 : pick(id_use_rt, int'(id_rt));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            hist[1] = hist[0];
            if (e_bub) hist[0] = '{0, 0, 0, 0};
            else hist[0] = '{1, int'(id_dest), id_reg_write, id_mem_read};
            m_fa = na;
            m_fb = nb;
            if (e_stall && m_cnt < CMAX) m_cnt++;
        end
        chk("fwdA", int'(fwdA), m_fa);
        chk("fwdB", int'(fwdB), m_fb);
        chk("stall_count", int'(stall_count), m_cnt);
    endtask

    initial begin
        int cnt0;
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        chk("reset_fwdA", int'(fwdA), 1);
        chk("reset_count", int'(stall_count), 0);
        #1;
        chk("reset_bubble", int'(id_ex_bubble), 1);

        // add $3,$1,$2 ; sub $5,$3,$4
        set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_id(1, 3, 4, 1, 1, 5, 1, 0); step();
        chk("dep1_fwdA", int'(fwdA), 2);
        chk("dep1_fwdB", int'(fwdB), 1);
        chk("dep1_nostall", int'(obs_stall), 0);

        // add $3 ; nop ; or $6,$7,$3
        set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 7, 3, 1, 1, 6, 1, 0); step();
        chk("dep2_fwdA", int'(fwdA), 1);
        chk("dep2_fwdB", int'(fwdB), 4);

        // lw $4,0($1) ; and $8,$4,$4
        cnt0 = int'(stall_count);
        set_id(1, 1, 0, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 8, 1, 0); step();
        chk("lu_stall", int'(obs_stall), 1);
        chk("lu_bubble", int'(obs_bub), 1);
        chk("lu_bubble_fwdA", int'(fwdA), 1);
        step();
        chk("lu_stall_after", int'(obs_stall), 0);
        chk("lu_fwdA", int'(fwdA), 4);
        chk("lu_fwdB", int'(fwdB), 4);
        chk("lu_count", int'(stall_count), cnt0 + 1);

        // add $2 ; add $2 ; sub $9,$2,$2
        set_id(1, 1, 1, 1, 1, 2, 1, 0); step();
        set_id(1, 3, 3, 1, 1, 2, 1, 0); step();
        set_id(1, 2, 2, 1, 1, 9, 1, 0); step();
        chk("young_fwdA", int'(fwdA), 2);
        chk("young_fwdB", int'(fwdB), 2);

        // Writes to $0 and a non-writing producer
        set_id(1, 1, 1, 1, 1, 0, 1, 1); step();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); step();
        chk("r0_nostall", int'(obs_stall), 0);
        chk("r0_fwdA", int'(fwdA), 1);
        chk("r0_fwdB", int'(fwdB), 1);
        set_id(1, 1, 1, 1, 1, 7, 0, 0); step();
        set_id(1, 7, 7, 1, 1, 5, 1, 0); step();
        chk("norw_fwdA", int'(fwdA), 1);

        // lw $4 with dependent in ID and flush
        cnt0 = int'(stall_count);
        set_id(1, 1, 0, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 8, 1, 0);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_stall", int'(obs_stall), 0);
        chk("flush_bubble", int'(obs_bub), 1);
        chk("flush_count", int'(stall_count), cnt0);

        // Reset during a load-use stall
        set_id(1, 1, 0, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 8, 1, 0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rst_fwdA", int'(fwdA), 1);
        chk("rst_fwdB", int'(fwdB), 1);
        chk("rst_count", int'(stall_count), 0);
        step();
        chk("rst_nostall", int'(obs_stall), 0);

        // Randomized traffic; a stalled ID instruction is held, as IF/ID would hold it
        for (int i = 0; i < 3000; i++) begin
            if (!(obs_stall && rst_n)) begin
                set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            end
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            chk("sel_onehot", int'($countones(fwdA)) + int'($countones(fwdB)), 2);
        end
        rst_n = 1'b1;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
